// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB full-speed transmitter: request codes, PIDs,
// FSM states and CRC16 constants.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    REQ_NONE  = 3'd0,
    REQ_DATA0 = 3'd1,
    REQ_ACK   = 3'd2,
    REQ_NAK   = 3'd3,
    REQ_STALL = 3'd4,
    REQ_DATA1 = 3'd5
  } tx_req_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  localparam logic [7:0]  PID_DATA0  = 8'hC3;
  localparam logic [7:0]  PID_DATA1  = 8'h4B;
  localparam logic [7:0]  PID_ACK    = 8'hD2;
  localparam logic [7:0]  PID_NAK    = 8'h5A;
  localparam logic [7:0]  PID_STALL  = 8'h1E;
  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [7:0] pid_byte(input logic [2:0] code);
    case (code)
      REQ_DATA0: return PID_DATA0;
      REQ_DATA1: return PID_DATA1;
      REQ_ACK:   return PID_ACK;
      REQ_NAK:   return PID_NAK;
      REQ_STALL: return PID_STALL;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic logic is_data_req(input logic [2:0] code);
    return (code == REQ_DATA0) || (code == REQ_DATA1);
  endfunction

  function automatic logic is_invalid_req(input logic [2:0] code);
    return code > REQ_DATA1;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (poly 0x8005), one payload bit per enable, MSB-feedback form.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ((din ^ crc_q[15]) ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_gen2.sv
// USB 1.1 full-speed packet transmitter: SYNC/PID/payload/CRC16 with bit
// stuffing and NRZI, followed by SE0-SE0-J end of packet.
module usb_tx_gen2
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_PAYLOAD  = 64,
  parameter int OCC_W        = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       tx_packet,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic [7:0]       tx_packet_data,
  output logic             get_tx_packet_data,
  output logic             tx_transfer_active,
  output logic             tx_error,
  output logic             tx_done,
  output logic             dplus_out,
  output logic             dminus_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       ones_q, ones_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       pid_q, pid_d;
  logic             is_data_q, is_data_d;
  logic             crc_hi_q, crc_hi_d;
  logic             stuff_q, stuff_d;
  logic             dplus_q, dplus_d;
  logic             dminus_q, dminus_d;
  logic             active_q, active_d;
  logic             get_q, get_d;
  logic             error_q, error_d;
  logic             done_q, done_d;

  logic             crc_clr, crc_en, crc_din;
  logic [15:0]      crc_val;
  logic             bit_end, start_bit, new_bit, to_eop;
  logic [LEN_W-1:0] len_cap;

  usb_crc16 u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (crc_clr),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc_val)
  );

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    ones_d     = ones_q;
    shift_d    = shift_q;
    pid_d      = pid_q;
    is_data_d  = is_data_q;
    crc_hi_d   = crc_hi_q;
    stuff_d    = stuff_q;
    dplus_d    = dplus_q;
    dminus_d   = dminus_q;
    active_d   = active_q;
    get_d      = 1'b0;
    error_d    = 1'b0;
    done_d     = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_din    = 1'b0;
    start_bit  = 1'b0;
    new_bit    = 1'b0;
    to_eop     = 1'b0;
    bit_end    = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    if (32'(buffer_occupancy) > 32'(MAX_PAYLOAD)) begin
      len_cap = LEN_W'(MAX_PAYLOAD);
    end else begin
      len_cap = LEN_W'(buffer_occupancy);
    end

    case (state_q)
      ST_IDLE: begin
        if (is_invalid_req(tx_packet)) begin
          error_d = 1'b1;
        end else if (tx_packet != REQ_NONE) begin
          state_d    = ST_SYNC;
          active_d   = 1'b1;
          is_data_d  = is_data_req(tx_packet);
          pid_d      = pid_byte(tx_packet);
          len_d      = len_cap;
          byte_cnt_d = '0;
          bit_idx_d  = '0;
          ones_d     = '0;
          stuff_d    = 1'b0;
          crc_hi_d   = 1'b0;
          crc_clr    = 1'b1;
          shift_d    = SYNC_BYTE;
          new_bit    = SYNC_BYTE[0];
          start_bit  = 1'b1;
        end
      end

      ST_EOP_SE0: begin
        if (!bit_end) begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end else begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd0) begin
            bit_idx_d = 3'd1;
          end else begin
            bit_idx_d = '0;
            state_d   = ST_EOP_J;
            dplus_d   = 1'b1;
            dminus_d  = 1'b0;
          end
        end
      end

      ST_EOP_J: begin
        if (!bit_end) begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end else begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          active_d  = 1'b0;
          done_d    = 1'b1;
          ones_d    = '0;
        end
      end

      default: begin
        if (!bit_end) begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end else begin
          start_bit = 1'b1;
          // A stuffed bit leaves bit_idx/byte_cnt untouched so the next
          // boundary resumes exactly where the data stream paused.
          if (ones_q == 3'd6) begin
            stuff_d = 1'b1;
            new_bit = 1'b0;
          end else begin
            stuff_d = 1'b0;
            if (bit_idx_q != 3'd7) begin
              bit_idx_d = bit_idx_q + 3'd1;
              new_bit   = shift_q[bit_idx_q + 3'd1];
            end else begin
              bit_idx_d = '0;
              case (state_q)
                ST_SYNC: begin
                  state_d = ST_PID;
                  shift_d = pid_q;
                  new_bit = pid_q[0];
                end
                ST_PID, ST_DATA: begin
                  if ((state_q == ST_PID) && !is_data_q) begin
                    to_eop = 1'b1;
                  end else if (byte_cnt_q != len_q) begin
                    state_d    = ST_DATA;
                    shift_d    = tx_packet_data;
                    new_bit    = tx_packet_data[0];
                    get_d      = 1'b1;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                  end else begin
                    state_d  = ST_CRC;
                    crc_hi_d = 1'b0;
                    shift_d  = ~crc_val[7:0];
                    new_bit  = ~crc_val[0];
                  end
                end
                default: begin
                  if (!crc_hi_q) begin
                    crc_hi_d = 1'b1;
                    shift_d  = ~crc_val[15:8];
                    new_bit  = ~crc_val[8];
                  end else begin
                    to_eop = 1'b1;
                  end
                end
              endcase
            end
          end
        end
      end
    endcase

    if (to_eop) begin
      state_d   = ST_EOP_SE0;
      clk_cnt_d = '0;
      bit_idx_d = '0;
      ones_d    = '0;
      dplus_d   = 1'b0;
      dminus_d  = 1'b0;
    end else if (start_bit) begin
      clk_cnt_d = '0;
      // NRZI: a 0 toggles J<->K, a 1 holds the current level.
      if (new_bit) begin
        dplus_d  = dplus_q;
        dminus_d = ~dplus_q;
      end else begin
        dplus_d  = ~dplus_q;
        dminus_d = dplus_q;
      end
      if (state_d != ST_SYNC) begin
        ones_d = (stuff_d || !new_bit) ? 3'd0 : ones_q + 3'd1;
      end
      if ((state_d == ST_DATA) && !stuff_d) begin
        crc_en  = 1'b1;
        crc_din = new_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      ones_q     <= '0;
      shift_q    <= '0;
      pid_q      <= '0;
      is_data_q  <= 1'b0;
      crc_hi_q   <= 1'b0;
      stuff_q    <= 1'b0;
      dplus_q    <= 1'b1;
      dminus_q   <= 1'b0;
      active_q   <= 1'b0;
      get_q      <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      ones_q     <= ones_d;
      shift_q    <= shift_d;
      pid_q      <= pid_d;
      is_data_q  <= is_data_d;
      crc_hi_q   <= crc_hi_d;
      stuff_q    <= stuff_d;
      dplus_q    <= dplus_d;
      dminus_q   <= dminus_d;
      active_q   <= active_d;
      get_q      <= get_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign get_tx_packet_data = get_q;
  assign tx_transfer_active = active_q;
  assign tx_error           = error_q;
  assign tx_done            = done_q;
  assign dplus_out          = dplus_q;
  assign dminus_out         = dminus_q;

endmodule
